// File: rtl/upcount_pkg.sv
// Shared types and defaults for the command-driven up-counter sequencer.
package upcount_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/upcount_core.sv
// Loadable modulo-2^WIDTH up counter; load takes priority over enable.
module upcount_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] c
);

    always_ff @(posedge clk) begin
        if (rst) begin
            c <= '0;
        end else if (load) begin
            c <= in;
        end else if (en) begin
            c <= c + WIDTH'(1);
        end
    end

endmodule

// File: rtl/upcount_seq.sv
// Accepts start/end commands over valid/ready and drives the counter from start
// up to end (wrapping), pulsing done on completion unless aborted or reset.
module upcount_seq
    import upcount_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_end,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [WIDTH-1:0] st_r;
    logic [WIDTH-1:0] end_r;
    logic             core_load;
    logic             core_en;

    // State, command latch and state-decoded outputs (registered from next state)
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            st_r      <= '0;
            end_r     <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == IDLE);
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);
            if (state == IDLE && cmd_valid) begin
                st_r  <= cmd_start;
                end_r <= cmd_end;
            end
        end
    end

    // Next state and counter controls; abort freezes the count in RUN
    always_comb begin
        state_nxt = state;
        core_load = 1'b0;
        core_en   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                core_load = 1'b1;
                state_nxt = abort ? IDLE : RUN;
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (count == end_r) begin
                    state_nxt = DONE;
                end else begin
                    core_en = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    upcount_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (core_load),
        .en   (core_en),
        .in   (st_r),
        .c    (count)
    );

endmodule
